// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC arm/trigger/capture controller.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_WAIT_INACTIVE = 3'd1,
    ST_ARMED         = 3'd2,
    ST_DELAY         = 3'd3,
    ST_CAPTURE       = 3'd4
  } state_e;

  localparam logic [1:0] TRIG_LOW  = 2'b00;
  localparam logic [1:0] TRIG_HIGH = 2'b01;
  localparam logic [1:0] TRIG_FALL = 2'b10;
  localparam logic [1:0] TRIG_RISE = 2'b11;

  function automatic logic is_level_mode(input logic [1:0] mode);
    return (mode == TRIG_LOW) || (mode == TRIG_HIGH);
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_trig_detect.sv
// Trigger qualifier: keeps the previous-cycle trigger and derives the hit and
// active flags for the selected mode.
module trig_detect
  import adc_capture_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       trig_i,
  input  logic [1:0] mode_i,
  output logic       hit_o,
  output logic       active_o
);

  logic trig_q;

  // previous-cycle trigger, updated in every state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_i;
    end
  end

  // hit/active decode per trigger mode
  always_comb begin
    hit_o    = 1'b0;
    active_o = 1'b0;
    case (mode_i)
      TRIG_LOW: begin
        hit_o    = ~trig_i;
        active_o = ~trig_i;
      end
      TRIG_HIGH: begin
        hit_o    = trig_i;
        active_o = trig_i;
      end
      TRIG_FALL: begin
        hit_o    = trig_q & ~trig_i;
        active_o = ~trig_i;
      end
      TRIG_RISE: begin
        hit_o    = ~trig_q & trig_i;
        active_o = trig_i;
      end
      default: begin
        hit_o    = 1'b0;
        active_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Arm/trigger/capture controller in the ADC sample clock domain: trigger modes,
// post-trigger delay, bounded capture length, decimation and overflow report.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int LEN_W  = 24,
  parameter int DLY_W  = 16,
  parameter int DEC_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_or_i,
  input  logic              trig_i,
  input  logic [1:0]        trig_mode_i,
  input  logic              trig_wait_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DLY_W-1:0]  trig_delay_i,
  input  logic [LEN_W-1:0]  capture_len_i,
  input  logic [DEC_W-1:0]  decimate_i,
  input  logic              fifo_full_i,
  output logic              fifo_wr_en_o,
  output logic [DATA_W:0]   fifo_din_o,
  output logic              armed_o,
  output logic              capturing_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [LEN_W-1:0]  sample_count_o,
  output logic [2:0]        state_o
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               wait_q, wait_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DEC_W-1:0]   dec_q, dec_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               wr_q, wr_d;
  logic [DATA_W:0]    din_q, din_d;
  logic               done_q, done_d;
  logic               armed_q, armed_d;
  logic               capt_q, capt_d;

  logic [1:0]         mode_sel_s;
  logic               hit_s;
  logic               active_s;
  logic               slot_s;

  // Before arming the live mode decides the wait; afterwards the shadow copy rules.
  always_comb begin
    if (state_q == ST_IDLE) begin
      mode_sel_s = trig_mode_i;
    end else begin
      mode_sel_s = mode_q;
    end
  end

  trig_detect u_trig_detect (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .trig_i   (trig_i),
    .mode_i   (mode_sel_s),
    .hit_o    (hit_s),
    .active_o (active_s)
  );

  // next-state, counters and registered output values
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wait_d    = wait_q;
    dly_d     = dly_q;
    len_d     = len_q;
    dec_d     = dec_q;
    dly_cnt_d = dly_cnt_q;
    dec_cnt_d = dec_cnt_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    wr_d      = 1'b0;
    din_d     = din_q;
    done_d    = 1'b0;
    slot_s    = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            mode_d = trig_mode_i;
            wait_d = trig_wait_i;
            dly_d  = trig_delay_i;
            len_d  = capture_len_i;
            dec_d  = decimate_i;
            cnt_d  = {LEN_W{1'b0}};
            ovf_d  = 1'b0;
            if (is_level_mode(trig_mode_i) && trig_wait_i && active_s) begin
              state_d = ST_WAIT_INACTIVE;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_INACTIVE: begin
          if (!active_s || !wait_q) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_WAIT_INACTIVE;
          end
        end
        ST_ARMED: begin
          if (hit_s) begin
            if (dly_q == {DLY_W{1'b0}}) begin
              slot_s = 1'b1;
            end else begin
              dly_cnt_d = dly_q - DLY_W'(1);
              state_d   = ST_DELAY;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_DELAY: begin
          if (dly_cnt_q == {DLY_W{1'b0}}) begin
            slot_s = 1'b1;
          end else begin
            dly_cnt_d = dly_cnt_q - DLY_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (dec_cnt_q == {DEC_W{1'b0}}) begin
            slot_s = 1'b1;
          end else begin
            dec_cnt_d = dec_cnt_q - DEC_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // A sample slot either takes a sample or, for a zero length, just completes.
      if (slot_s) begin
        if (len_q == {LEN_W{1'b0}}) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wr_d      = ~fifo_full_i;
          din_d     = {adc_or_i, adc_data_i};
          ovf_d     = ovf_q | fifo_full_i;
          cnt_d     = cnt_q + LEN_W'(1);
          dec_cnt_d = dec_q;
          if (cnt_q == len_q - LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end else begin
        slot_s = 1'b0;
      end
    end

    armed_d = (state_d == ST_WAIT_INACTIVE) || (state_d == ST_ARMED);
    capt_d  = (state_d == ST_DELAY) || (state_d == ST_CAPTURE);
  end

  // state, shadow configuration, counters and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= 2'b00;
      wait_q    <= 1'b0;
      dly_q     <= {DLY_W{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      dec_q     <= {DEC_W{1'b0}};
      dly_cnt_q <= {DLY_W{1'b0}};
      dec_cnt_q <= {DEC_W{1'b0}};
      cnt_q     <= {LEN_W{1'b0}};
      ovf_q     <= 1'b0;
      wr_q      <= 1'b0;
      din_q     <= {(DATA_W+1){1'b0}};
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      capt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wait_q    <= wait_d;
      dly_q     <= dly_d;
      len_q     <= len_d;
      dec_q     <= dec_d;
      dly_cnt_q <= dly_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      din_q     <= din_d;
      done_q    <= done_d;
      armed_q   <= armed_d;
      capt_q    <= capt_d;
    end
  end

  assign fifo_wr_en_o   = wr_q;
  assign fifo_din_o     = din_q;
  assign armed_o        = armed_q;
  assign capturing_o    = capt_q;
  assign done_o         = done_q;
  assign overflow_o     = ovf_q;
  assign sample_count_o = cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: each scenario's expected outputs are
// derived from the trigger/sample schedule rules, then compared cycle by cycle.
module tb_adc_capture_ctrl;
  import adc_capture_pkg::*;

  localparam int DATA_W = 10;
  localparam int LEN_W  = 24;
  localparam int DLY_W  = 16;
  localparam int DEC_W  = 8;
  localparam int NMAX   = 1024;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [DATA_W-1:0] adc_data_i;
  logic              adc_or_i;
  logic              trig_i;
  logic [1:0]        trig_mode_i;
  logic              trig_wait_i;
  logic              arm_i;
  logic              abort_i;
  logic [DLY_W-1:0]  trig_delay_i;
  logic [LEN_W-1:0]  capture_len_i;
  logic [DEC_W-1:0]  decimate_i;
  logic              fifo_full_i;
  logic              fifo_wr_en_o;
  logic [DATA_W:0]   fifo_din_o;
  logic              armed_o;
  logic              capturing_o;
  logic              done_o;
  logic              overflow_o;
  logic [LEN_W-1:0]  sample_count_o;
  logic [2:0]        state_o;

  always #5 clk_i = ~clk_i;

  adc_capture_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DLY_W(DLY_W), .DEC_W(DEC_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .adc_data_i(adc_data_i), .adc_or_i(adc_or_i),
    .trig_i(trig_i), .trig_mode_i(trig_mode_i), .trig_wait_i(trig_wait_i), .arm_i(arm_i),
    .abort_i(abort_i), .trig_delay_i(trig_delay_i), .capture_len_i(capture_len_i),
    .decimate_i(decimate_i), .fifo_full_i(fifo_full_i), .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_din_o(fifo_din_o), .armed_o(armed_o), .capturing_o(capturing_o), .done_o(done_o),
    .overflow_o(overflow_o), .sample_count_o(sample_count_o), .state_o(state_o)
  );

  int vectors = 0;
  int errors  = 0;

  // per-cycle scenario stimulus
  logic              trig_a [NMAX];
  logic              full_a [NMAX];
  logic              or_a   [NMAX];
  logic [DATA_W-1:0] data_a [NMAX];
  // {idle, wr, din, done, armed, capturing, overflow, count}
  logic [40:0]       obs    [NMAX];
  logic [40:0]       exp_v  [NMAX];

  logic              last_trig = 1'b0;
  logic [LEN_W-1:0]  prev_cnt  = '0;
  logic              prev_ovf  = 1'b0;

  logic [1:0] s_mode;
  logic       s_wait;
  int s_dly, s_len, s_dec, s_arm, s_arm2, s_abort, s_n;

  task automatic init_scen(input int n, input logic t0);
    s_n = n; s_arm = 1; s_arm2 = -1; s_abort = n - 1;
    s_mode = TRIG_RISE; s_wait = 1'b0; s_dly = 0; s_len = 1; s_dec = 0;
    for (int c = 0; c < n; c++) begin
      trig_a[c] = t0;
      full_a[c] = 1'b0;
      data_a[c] = DATA_W'($urandom);
      or_a[c]   = 1'($urandom);
    end
  endtask

  // Reference: find arming point, trigger hit, sample schedule, then outputs.
  task automatic model_scen();
    int p, t, e, x;
    logic lvl, lvl_mode, tp;
    logic take [NMAX];
    logic [LEN_W-1:0] cnt;
    logic ovf;
    lvl = s_mode[0];
    lvl_mode = !s_mode[1];
    x = s_abort;
    p = s_arm + 1;
    if (lvl_mode && s_wait && trig_a[s_arm] == lvl) begin
      p = s_n;
      for (int c = s_arm + 1; c < s_n; c++) if (trig_a[c] != lvl) begin p = c + 1; break; end
    end
    t = s_n;
    for (int c = p; c < s_n; c++) begin
      tp = (c == 0) ? last_trig : trig_a[c-1];
      if (trig_a[c] == lvl && (lvl_mode || trig_a[c] != tp)) begin t = c; break; end
    end
    e = (s_len > 0) ? t + s_dly + (s_len - 1) * (s_dec + 1) : t + s_dly;
    for (int c = 0; c < s_n; c++) take[c] = 1'b0;
    if (t < s_n)
      for (int k = 0; k < s_len; k++) begin
        int s;
        s = t + s_dly + k * (s_dec + 1);
        if (s < s_n && s < x) take[s] = 1'b1;
      end
    cnt = prev_cnt;
    ovf = prev_ovf;
    for (int c = 0; c < s_n; c++) begin
      logic wr, dn, arm_e, cap_e;
      if (c == s_arm) begin cnt = '0; ovf = 1'b0; end
      if (take[c]) begin cnt = cnt + 1'b1; if (full_a[c]) ovf = 1'b1; end
      wr    = take[c] && !full_a[c];
      dn    = (t < s_n) && (c == e) && (c < x);
      arm_e = (c >= s_arm) && (c < t) && (c < x);
      cap_e = (t < s_n) && (c >= t) && (c < e) && (c < x);
      exp_v[c] = {!(arm_e || cap_e), wr, wr ? {or_a[c], data_a[c]} : 11'd0,
                  dn, arm_e, cap_e, ovf, cnt};
    end
    prev_cnt = cnt;
    prev_ovf = ovf;
  endtask

  task automatic apply_scen();
    for (int c = 0; c < s_n; c++) begin
      trig_i = trig_a[c]; fifo_full_i = full_a[c]; adc_data_i = data_a[c]; adc_or_i = or_a[c];
      arm_i = (c == s_arm) || (c == s_arm2);
      abort_i = (c == s_abort);
      if (c == s_arm) begin
        trig_mode_i = s_mode; trig_wait_i = s_wait; trig_delay_i = DLY_W'(s_dly);
        capture_len_i = LEN_W'(s_len); decimate_i = DEC_W'(s_dec);
      end else begin
        trig_mode_i = 2'($urandom); trig_wait_i = 1'($urandom); trig_delay_i = DLY_W'($urandom);
        capture_len_i = LEN_W'($urandom); decimate_i = DEC_W'($urandom);
      end
      @(posedge clk_i); #1;
      obs[c] = {state_o == 3'd0, fifo_wr_en_o, fifo_wr_en_o ? fifo_din_o : 11'd0,
                done_o, armed_o, capturing_o, overflow_o, sample_count_o};
    end
    arm_i = 1'b0; abort_i = 1'b0;
    last_trig = trig_a[s_n-1];
  endtask

  task automatic run_scen();
    model_scen();
    apply_scen();
  endtask

  task automatic test_reset();
    reset_i = 1'b1; adc_data_i = '0; adc_or_i = 1'b0; trig_i = 1'b0; trig_mode_i = 2'b00;
    trig_wait_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trig_delay_i = '0; capture_len_i = '0;
    decimate_i = '0; fifo_full_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if ({state_o, fifo_wr_en_o, fifo_din_o, done_o, armed_o, capturing_o, overflow_o, sample_count_o} !== 44'd0) begin
      errors++;
      $display("FAIL reset_hold: got state=%0d wr=%b din=%h done=%b armed=%b capt=%b ovf=%b cnt=%0d, expected all 0",
               state_o, fifo_wr_en_o, fifo_din_o, done_o, armed_o, capturing_o, overflow_o, sample_count_o);
    end
    @(negedge clk_i); reset_i = 1'b0;
    @(posedge clk_i); #1;
    vectors++;
    if ({state_o, fifo_wr_en_o, done_o, armed_o, capturing_o, overflow_o, sample_count_o} !== 33'd0) begin
      errors++;
      $display("FAIL reset_release: got state=%0d armed=%b cnt=%0d, expected idle/0", state_o, armed_o, sample_count_o);
    end
  endtask

  task automatic test_rise_basic();
    init_scen(20, 1'b0);
    for (int c = 6; c < 20; c++) trig_a[c] = 1'b1;
    for (int c = 0; c < 20; c++) data_a[c] = DATA_W'(c);
    s_mode = TRIG_RISE; s_arm = 2; s_len = 4;
    run_scen();
    for (int c = 0; c < s_n; c++) begin
      vectors++;
      if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL rise_basic cyc %0d: got %h expected %h", c, obs[c], exp_v[c]); end
    end
  endtask

  task automatic test_wait_level();
    init_scen(60, 1'b1);
    for (int c = 8; c < 11; c++) trig_a[c] = 1'b0;
    s_mode = TRIG_HIGH; s_wait = 1'b1; s_arm = 2;
    s_dly = $urandom_range(0, 3); s_len = $urandom_range(1, 5); s_dec = $urandom_range(0, 2);
    run_scen();
    for (int c = 0; c < s_n; c++) begin
      vectors++;
      if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL wait_level cyc %0d: got %h expected %h", c, obs[c], exp_v[c]); end
    end
  endtask

  task automatic test_delay_decimate();
    for (int r = 0; r < 2; r++) begin
      init_scen(r == 0 ? 30 : 300, 1'b1);
      for (int c = 5; c < s_n; c++) trig_a[c] = 1'b0;
      s_mode = TRIG_LOW;
      s_dly = (r == 0) ? 5 : 1; s_dec = (r == 0) ? 2 : 255; s_len = (r == 0) ? 3 : 2;
      run_scen();
      for (int c = 0; c < s_n; c++) begin
        vectors++;
        if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL delay_dec%0d cyc %0d: got %h expected %h", r, c, obs[c], exp_v[c]); end
      end
    end
  endtask

  task automatic test_overflow();
    for (int r = 0; r < 2; r++) begin
      init_scen(16, 1'b0);
      for (int c = 4; c < 16; c++) trig_a[c] = 1'b1;
      s_mode = TRIG_RISE; s_len = 4;
      if (r == 0) full_a[5] = 1'b1;
      else s_dec = 1;
      run_scen();
      for (int c = 0; c < s_n; c++) begin
        vectors++;
        if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL overflow%0d cyc %0d: got %h expected %h", r, c, obs[c], exp_v[c]); end
      end
    end
  endtask

  task automatic test_abort();
    for (int r = 0; r < 2; r++) begin
      init_scen(20, 1'b0);
      for (int c = 4; c < 20; c++) trig_a[c] = 1'b1;
      s_mode = TRIG_RISE; s_len = 3;
      if (r == 0) begin s_dly = 6; s_abort = 7; end
      else begin s_dec = 1; s_abort = 8; end
      run_scen();
      for (int c = 0; c < s_n; c++) begin
        vectors++;
        if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL abort%0d cyc %0d: got %h expected %h", r, c, obs[c], exp_v[c]); end
      end
    end
  endtask

  task automatic test_len_zero();
    for (int r = 0; r < 2; r++) begin
      init_scen(16, 1'b1);
      for (int c = 5; c < 16; c++) trig_a[c] = 1'b0;
      s_mode = TRIG_FALL; s_len = 0; s_dly = (r == 0) ? 0 : 3;
      run_scen();
      for (int c = 0; c < s_n; c++) begin
        vectors++;
        if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL len_zero%0d cyc %0d: got %h expected %h", r, c, obs[c], exp_v[c]); end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      init_scen(120, last_trig);
      for (int c = 0; c < s_n; c++) begin
        trig_a[c] = ((c == 0) ? last_trig : trig_a[c-1]) ^ ($urandom_range(0, 3) == 0);
        full_a[c] = ($urandom_range(0, 3) == 0);
      end
      s_mode = 2'($urandom); s_wait = 1'($urandom);
      s_dly = $urandom_range(0, 10); s_len = $urandom_range(0, 8); s_dec = $urandom_range(0, 4);
      s_arm = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) s_arm2 = s_arm + 1;
      if ($urandom_range(0, 3) == 0) s_abort = $urandom_range(s_arm + 1, s_n - 2);
      run_scen();
      for (int c = 0; c < s_n; c++) begin
        vectors++;
        if (obs[c] !== exp_v[c]) begin errors++; $display("FAIL random%0d cyc %0d: got %h expected %h", r, c, obs[c], exp_v[c]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    trig_mode_i = TRIG_RISE; trig_wait_i = 1'b0; trig_delay_i = '0; capture_len_i = 24'd100;
    decimate_i = '0; trig_i = 1'b0; fifo_full_i = 1'b0; abort_i = 1'b0;
    arm_i = 1'b1;
    @(posedge clk_i); #1;
    arm_i = 1'b0;
    @(posedge clk_i); #1;
    trig_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adc_data_i = DATA_W'($urandom);
      @(posedge clk_i); #1;
    end
    vectors++;
    if (capturing_o !== 1'b1 || sample_count_o !== 24'd5) begin
      errors++;
      $display("FAIL mid_capture: got capt=%b cnt=%0d, expected capt=1 cnt=5", capturing_o, sample_count_o);
    end
    #2 reset_i = 1'b1;
    #1;
    vectors++;
    if ({state_o, fifo_wr_en_o, fifo_din_o, done_o, armed_o, capturing_o, overflow_o, sample_count_o} !== 44'd0) begin
      errors++;
      $display("FAIL reset_mid: got state=%0d wr=%b din=%h done=%b capt=%b cnt=%0d, expected all 0",
               state_o, fifo_wr_en_o, fifo_din_o, done_o, capturing_o, sample_count_o);
    end
    @(negedge clk_i); reset_i = 1'b0; trig_i = 1'b0;
    @(posedge clk_i); #1;
    vectors++;
    if (state_o !== 3'd0 || capturing_o !== 1'b0 || sample_count_o !== 24'd0) begin
      errors++;
      $display("FAIL reset_mid_after: got state=%0d capt=%b cnt=%0d, expected 0", state_o, capturing_o, sample_count_o);
    end
    last_trig = 1'b0; prev_cnt = '0; prev_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_basic();
    test_wait_level();
    test_delay_decimate();
    test_overflow();
    test_abort();
    test_len_zero();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Parametrised arm/trigger/capture controller for the ADC sample path, running entirely in the ADC sample clock domain. It replaces the fixed level-only arm/trigger logic with four trigger modes, a post-trigger delay, a bounded capture length, decimation and FIFO overflow reporting. It sits between the registered ADC data and the sample FIFO that feeds the USB readout. All control inputs are already synchronised to `clk_i` upstream.

## Interface
Parameters:
- `DATA_W`, 10: ADC sample width.
- `LEN_W`, 24: width of capture length and sample counter.
- `DLY_W`, 16: width of trigger delay.
- `DEC_W`, 8: width of decimation factor.

Ports:
- `clk_i` in 1: ADC sample clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `adc_data_i` in DATA_W: registered ADC sample.
- `adc_or_i` in 1: ADC overrange flag for the same sample.
- `trig_i` in 1: trigger input, synchronous.
- `trig_mode_i` in 2: 00 low level, 01 high level, 10 falling edge, 11 rising edge.
- `trig_wait_i` in 1: level modes only; 1 = require trigger inactive before arming.
- `arm_i` in 1: single-cycle arm request.
- `abort_i` in 1: single-cycle abort.
- `trig_delay_i` in DLY_W: samples skipped after trigger.
- `capture_len_i` in LEN_W: samples to capture.
- `decimate_i` in DEC_W: keep one of every `decimate_i+1` samples.
- `fifo_full_i` in 1: sample FIFO full.
- `fifo_wr_en_o` out 1: FIFO write strobe.
- `fifo_din_o` out DATA_W+1: {overrange, sample}.
- `armed_o` out 1: in WAIT_INACTIVE or ARMED.
- `capturing_o` out 1: in DELAY or CAPTURE.
- `done_o` out 1: single-cycle capture-complete pulse.
- `overflow_o` out 1: sticky, a sample was dropped due to a full FIFO.
- `sample_count_o` out LEN_W: samples taken (written + dropped) this capture.
- `state_o` out 3: current state encoding.

## Operation
- States: IDLE, WAIT_INACTIVE, ARMED, DELAY, CAPTURE.
- IDLE + `arm_i`:
  - Latch `trig_mode_i`, `trig_wait_i`, `trig_delay_i`, `capture_len_i` and `decimate_i` into shadow registers; later input changes are ignored until the next arm.
  - Clear `overflow_o` and `sample_count_o`.
  - Go to WAIT_INACTIVE if a level mode is selected, wait=1 and the trigger is active; otherwise go to ARMED.
- `arm_i` outside IDLE: ignored.
- WAIT_INACTIVE → ARMED on the first cycle the trigger is inactive.
- Trigger-hit qualifier:
  - Level modes: `trig_i` equals the mode level.
  - Edge modes: `trig_i` differs from `trig_q`, the previous-cycle `trig_i`, in the selected direction. `trig_q` updates every cycle in all states, and its reset value is 0.
- ARMED + hit at cycle T:
  - Delay 0: the sample on `adc_data_i` at T is sample 0, and the FSM enters CAPTURE.
  - Delay D>0: go to DELAY, skip D samples; sample 0 is the input at T+D.
- CAPTURE:
  - Sample k (k = 0..len-1) is taken at T+D+k·(decimate+1); intermediate samples are discarded.
  - Each taken sample increments `sample_count_o`.
  - If `fifo_full_i` is low, the sample is written. If high, the write is suppressed and `overflow_o` sets; the timebase is unaffected.
  - After sample len-1, pulse `done_o` and return to IDLE.
- `capture_len` = 0: at the hit (D=0) or end of DELAY, pulse `done_o` with no write, then go to IDLE.
- `abort_i` in any state → IDLE next cycle, with no `done_o`. Abort wins over a simultaneous `arm_i`, hit or final sample.
- Arithmetic: counters are unsigned and do not wrap. The maximum length 2^LEN_W−1 and maximum delay are handled exactly.

## Timing
- Reset values: state IDLE; all outputs 0; shadow registers 0; `trig_q` 0.
- All outputs are registered.
- Sample taken at cycle S → `fifo_wr_en_o`/`fifo_din_o` valid at S+1, for exactly one cycle.
- `sample_count_o` updates at S+1.
- `done_o` is coincident with the final write strobe, or with the would-be write if that sample is dropped.
- `armed_o`/`capturing_o` track `state_o`, which updates at the edge after the triggering event.
- `overflow_o` holds until the next accepted `arm_i` or reset.
- Asserting `reset_i` mid-capture immediately forces IDLE and zeroes all outputs.

## Structure
- Package `adc_capture_pkg`: state encodings, trigger-mode constants (`TRIG_LOW`, `TRIG_HIGH`, `TRIG_FALL`, `TRIG_RISE`).
- Sub-module `trig_detect`: holds `trig_q` and produces the hit and active qualifiers from mode + `trig_i`.

## Test plan
- Rising edge, delay 0, len 4, dec 0: trigger rises at T with a ramp input → writes of ramp values at T..T+3, strobes at T+1..T+4, `done_o` at T+4, `sample_count_o`=4.
- High level, wait=1, trigger high at arm → stays WAIT_INACTIVE. Trigger low 3 cycles → ARMED. Trigger high → capture starts.
- Delay 5, dec 2, len 3 → samples taken at T+5, T+8, T+11; `done_o` with the third strobe.
- `fifo_full_i` high for the 2nd of 4 samples → 3 strobes, `overflow_o`=1, `sample_count_o`=4, `done_o` on schedule. Next `arm_i` clears `overflow_o`.
- `abort_i` in DELAY, plus `abort_i` coincident with the final sample → IDLE, no `done_o`, no further strobes.
- len 0 with falling-edge trigger → `done_o` one cycle after the edge, zero writes. Also `reset_i` mid-CAPTURE → all outputs 0 immediately.
